// File: rtl/fifo_flops.sv
// fifo_flops_reader: read-side controller for fifo_flops.
// Drains the FIFO through pop/pndng/Dout into a 2-entry skid buffer and
// presents the head word on a valid/ready stream. pop never depends on
// out_ready, so there is no combinational path from downstream to the FIFO.
// Optional statistics (word count and running XOR of popped words) are
// compiled in when the macro FIFO_RD_STATS_EN is defined.
module fifo_flops_reader #(
  parameter int bits  = 16,
  parameter int cnt_w = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic            pndng,
  input  logic [bits-1:0] Dout,
  output logic            pop,
  output logic [bits-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [cnt_w-1:0] rd_count,
  output logic [bits-1:0]  rd_xor
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t            occ_q;
  logic [bits-1:0] entry0_q;
  logic [bits-1:0] entry1_q;
  logic            transfer;

  // Pop only when the buffer has a free slot; reset forces it low all cycle.
  assign pop       = rst & rd_en & pndng & (occ_q != TWO);
  assign out_valid = (occ_q != EMPTY);
  assign out_data  = entry0_q;
  assign transfer  = out_valid & out_ready;

  // Occupancy FSM: capture Dout into the first free slot, shift e1 to e0 on a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q    <= EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (pop) begin
            occ_q    <= ONE;
            entry0_q <= Dout;
          end
        end
        ONE: begin
          if (pop && transfer) begin
            entry0_q <= Dout;
          end else if (pop) begin
            occ_q    <= TWO;
            entry1_q <= Dout;
          end else if (transfer) begin
            occ_q <= EMPTY;
          end
        end
        TWO: begin
          if (transfer) begin
            occ_q    <= ONE;
            entry0_q <= entry1_q;
          end
        end
        default: begin
          occ_q <= EMPTY;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [cnt_w-1:0] rdCount_q;
  logic [cnt_w-1:0] rdCount_d;
  logic [bits-1:0]  rdXor_q;
  logic [bits-1:0]  rdXor_d;

  assign rdCount_d = rdCount_q + cnt_w'(1);
  assign rdXor_d   = rdXor_q ^ Dout;
  assign rd_count  = rdCount_q;
  assign rd_xor    = rdXor_q;

  // Statistics follow every popped word on the same edge as its capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdCount_q <= '0;
      rdXor_q   <= '0;
    end else if (pop) begin
      rdCount_q <= rdCount_d;
      rdXor_q   <= rdXor_d;
    end
  end
`endif

endmodule
